// File: rtl/logic_op_pipe.sv
// WIDTH-bit bitwise logic unit: 8 opcode-selected functions behind a 2-stage valid/ready pipeline,
// with a built-in sweep that replays every {a,b} row of every op into a 32-bit truth-table word.
module logic_op_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [31:0]      sweep_tt,
  output logic             sweep_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOT_A = 3'd6;

  localparam logic [31:0] TT_GOLDEN = 32'hC39176E8;

  function automatic logic [WIDTH-1:0] f_logic(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_NAND:  return ~(a & b);
      OP_NOR:   return ~(a | b);
      OP_XNOR:  return ~(a ^ b);
      OP_NOT_A: return ~a;
      default:  return a;
    endcase
  endfunction

  // State
  logic [1:0]       r_state;
  logic [4:0]       r_k;
  logic [4:0]       r_cap_idx;
  logic             r_s0_valid;
  logic             r_s0_sweep;
  logic [WIDTH-1:0] r_s0_a;
  logic [WIDTH-1:0] r_s0_b;
  logic [2:0]       r_s0_op;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_y;
  logic             r_out_zero;
  logic             r_s1_sweep;
  logic [WIDTH-1:0] r_sw_res;
  logic [31:0]      r_sweep_tt;
  logic             r_sweep_done;
  logic             r_sweep_err;

  // Combinational
  logic             w_s1_load;
  logic             w_s0_load;
  logic             w_start_ok;
  logic             w_accept_window;
  logic             w_xfer;
  logic             w_issue;
  logic [WIDTH-1:0] w_alu_y;
  logic             w_sw_bits_ok;
  logic             w_last_cap;
  logic [31:0]      w_tt_next;

  assign w_s1_load       = !r_out_valid || out_ready;
  assign w_s0_load       = !(r_s0_valid || r_s0_sweep) || w_s1_load;
  assign w_start_ok      = (r_state == ST_IDLE) && sweep_start && !r_s0_valid && !r_out_valid;
  assign w_accept_window = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // An accepted start wins over a same-cycle beat so the sweep always sees an empty pipeline.
  assign in_ready        = w_accept_window && !w_start_ok && (!r_s0_valid || w_s1_load);
  assign w_xfer          = in_valid && in_ready;
  assign w_issue         = (r_state == ST_RUN) && w_s0_load;
  assign w_alu_y         = f_logic(r_s0_op, r_s0_a, r_s0_b);
  assign w_sw_bits_ok    = (&r_sw_res) || !(|r_sw_res);
  assign w_last_cap      = r_s1_sweep && (r_cap_idx == 5'd31);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_tt_next = r_sweep_tt;
    if (r_s1_sweep) w_tt_next[r_cap_idx] = r_sw_res[0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_sweep <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_op    <= '0;
    end else if (w_s0_load) begin
      r_s0_valid <= w_xfer;
      r_s0_sweep <= w_issue;
      if (w_issue) begin
        r_s0_a  <= {WIDTH{r_k[1]}};
        r_s0_b  <= {WIDTH{r_k[0]}};
        r_s0_op <= r_k[4:2];
      end else if (w_xfer) begin
        r_s0_a  <= in_a;
        r_s0_b  <= in_b;
        r_s0_op <= in_op;
      end
    end
  end

  // Sweep results live in their own register so out_y keeps its last external value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_zero  <= 1'b0;
      r_s1_sweep  <= 1'b0;
      r_sw_res    <= '0;
    end else if (w_s1_load) begin
      r_out_valid <= r_s0_valid;
      r_s1_sweep  <= r_s0_sweep;
      if (r_s0_valid) begin
        r_out_y    <= w_alu_y;
        r_out_zero <= ~(|w_alu_y);
      end
      if (r_s0_sweep) r_sw_res <= w_alu_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_cap_idx    <= '0;
      r_sweep_tt   <= '0;
      r_sweep_done <= 1'b0;
      r_sweep_err  <= 1'b0;
    end else begin
      if (r_s1_sweep) begin
        r_sweep_tt <= w_tt_next;
        r_cap_idx  <= r_cap_idx + 5'd1;
        if (!w_sw_bits_ok) r_sweep_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state      <= ST_RUN;
            r_k          <= '0;
            r_cap_idx    <= '0;
            r_sweep_tt   <= '0;
            r_sweep_done <= 1'b0;
            r_sweep_err  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_k <= r_k + 5'd1;
            if (r_k == 5'd31) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Final golden compare folds in the bit being captured on this same edge.
          if (w_last_cap) begin
            r_state      <= ST_DONE;
            r_sweep_done <= 1'b1;
            r_sweep_err  <= r_sweep_err || !w_sw_bits_ok || (w_tt_next != TT_GOLDEN);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_y      = r_out_y;
  assign out_zero   = r_out_zero;
  assign sweep_busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign sweep_done = r_sweep_done;
  assign sweep_tt   = r_sweep_tt;
  assign sweep_err  = r_sweep_err;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: vector table, stalled stream, self-test sweep timing,
// ignored/aborted sweeps and an injected sweep fault, with a queue-based output scoreboard.
module tb_logic_op_pipe;

  localparam int          W      = 8;
  localparam logic [31:0] GOLDEN = 32'hC39176E8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_zero;
  logic         sweep_start;
  logic         sweep_busy;
  logic         sweep_done;
  logic [31:0]  sweep_tt;
  logic         sweep_err;

  logic_op_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .sweep_tt(sweep_tt), .sweep_err(sweep_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] y;
  } vec_t;

  int           n_tests  = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           n_popped = 0;
  logic [W-1:0] exp_q[$];
  bit           sweep_watch = 1'b0;
  bit           prev_stall  = 1'b0;
  logic [W-1:0] prev_y;
  logic [W-1:0] mon_e;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each result bit looks up its {op,a,b} row in the golden truth-table word.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    logic [31:0]  g;
    logic [W-1:0] y;
    g = GOLDEN;
    for (int i = 0; i < W; i++) y[i] = g[{op, a[i], b[i]}];
    return y;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sweep_watch) check("sweep_out_valid_low", {31'b0, out_valid}, 32'd0);
      if (prev_stall && out_valid) check("stall_hold_y", {24'b0, out_y}, {24'b0, prev_y});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got y=%h with nothing expected", out_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_y", {24'b0, out_y}, {24'b0, mon_e});
          check("out_zero", {31'b0, out_zero}, {31'b0, (mon_e == '0)});
          n_popped++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = out_y;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat transferred.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                      input logic [W-1:0] y);
    int n = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for op=%0d", op);
    end else begin
      exp_q.push_back(y);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  // Called at posedge+1; start is sampled at the next edge T.
  task automatic run_sweep(input bit inject);
    int bad = 0;
    sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    sweep_watch = 1'b1;
    for (int j = 1; j <= 34; j++) begin
      @(negedge clk);
      if (!sweep_busy || sweep_done || in_ready) bad++;
      if (j == 20) sweep_start = 1'b1;
      if (j == 21) sweep_start = 1'b0;
      if (inject && j == 6) force dut.w_alu_y = 8'h5A;
      if (inject && j == 7) release dut.w_alu_y;
    end
    check("sweep_busy_window", bad, 32'd0);
    @(negedge clk);
    check("sweep_done_at_T35", {31'b0, sweep_done}, 32'd1);
    check("sweep_busy_clear", {31'b0, sweep_busy}, 32'd0);
    sweep_watch = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   t0;
    int   base;

    tbl[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0};
    tbl[1] = '{8'hF0, 8'hCC, 3'd1, 8'hFC};
    tbl[2] = '{8'hF0, 8'hCC, 3'd2, 8'h3C};
    tbl[3] = '{8'hF0, 8'hCC, 3'd3, 8'h3F};
    tbl[4] = '{8'hF0, 8'hCC, 3'd4, 8'h03};
    tbl[5] = '{8'hF0, 8'hCC, 3'd5, 8'hC3};
    tbl[6] = '{8'hF0, 8'hCC, 3'd6, 8'h0F};
    tbl[7] = '{8'hF0, 8'hCC, 3'd7, 8'hF0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b1; sweep_start = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_y", {24'b0, out_y}, 32'd0);
    check("rst_out_zero", {31'b0, out_zero}, 32'd0);
    check("rst_busy", {31'b0, sweep_busy}, 32'd0);
    check("rst_done", {31'b0, sweep_done}, 32'd0);
    check("rst_tt", sweep_tt, 32'd0);
    check("rst_err", {31'b0, sweep_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Single-beat latency: accepted at edge N, visible after edge N+1
    @(posedge clk);
    #1 in_a = 8'hF0; in_b = 8'hCC; in_op = 3'd0; in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", {31'b0, in_ready}, 32'd1);
    exp_q.push_back(8'hC0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle_n1_invalid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle_n2_valid", {31'b0, out_valid}, 32'd1);
    drain("lat_drain");

    // All 8 ops back-to-back at full rate
    @(posedge clk);
    #1 t0 = cyc;
    for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].y);
    check("table_throughput_cycles", cyc - t0, 32'd8);
    drain("table_drain");

    // 10-beat stream with out_ready low for 4 cycles
    @(posedge clk);
    #1 base = n_popped;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [W-1:0] a;
          logic [W-1:0] b;
          logic [2:0]   op;
          a  = W'($urandom);
          b  = W'($urandom);
          op = 3'(i);
          send(a, b, op, model(a, b, op));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("stream_drain");
    check("stream_count", n_popped - base, 32'd10);

    // Clean sweep, with a second start pulsed mid-run
    @(posedge clk);
    #1 run_sweep(1'b0);
    check("sweep_tt_golden", sweep_tt, GOLDEN);
    check("sweep_err_clean", {31'b0, sweep_err}, 32'd0);
    repeat (3) @(negedge clk);
    check("sweep_done_held", {31'b0, sweep_done}, 32'd1);
    check("sweep_tt_held", sweep_tt, GOLDEN);

    // Start with a beat stuck in the pipeline is dropped
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd2, 8'h26);
    repeat (2) @(posedge clk);
    #1 sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    @(negedge clk);
    check("start_busy_ignored", {31'b0, sweep_busy}, 32'd0);
    check("start_done_kept", {31'b0, sweep_done}, 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain("inflight_drain");
    repeat (3) @(negedge clk);
    check("start_not_queued", {31'b0, sweep_busy}, 32'd0);

    // Reset at T+10 aborts the sweep
    @(posedge clk);
    #1 sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("abort_was_busy", {31'b0, sweep_busy}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, sweep_busy}, 32'd0);
    check("abort_done", {31'b0, sweep_done}, 32'd0);
    check("abort_tt", sweep_tt, 32'd0);
    check("abort_err", {31'b0, sweep_err}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);

    // Sweep with one corrupted result
    @(posedge clk);
    #1 run_sweep(1'b1);
    check("fault_err", {31'b0, sweep_err}, 32'd1);

    // External traffic resumes after a sweep
    @(posedge clk);
    #1 send(8'hA5, 8'h0F, 3'd3, 8'hFA);
    send(8'h00, 8'hFF, 3'd7, 8'h00);
    send(8'h3C, 8'hFF, 3'd6, 8'hC3);
    drain("post_sweep_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
